// File: rtl/corr_frame_buffer.sv
// Ping-pong frame buffer between the correlation accumulator and the per-channel
// solver. It captures whole frames into two RAM banks and replays them over valid/ready.
module corr_frame_buffer #(
  parameter int DIN_WIDTH  = 32,
  parameter int VECTOR_LEN = 64,
  localparam int IDX_W     = $clog2(VECTOR_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIN_WIDTH-1:0] r11,
  input  logic [DIN_WIDTH-1:0] r22,
  input  logic [DIN_WIDTH-1:0] r12_re,
  input  logic [DIN_WIDTH-1:0] r12_im,
  input  logic                 din_valid,
  output logic [DIN_WIDTH-1:0] dout_r11,
  output logic [DIN_WIDTH-1:0] dout_r22,
  output logic [DIN_WIDTH-1:0] dout_r12_re,
  output logic [DIN_WIDTH-1:0] dout_r12_im,
  output logic [IDX_W-1:0]     dout_index,
  output logic                 dout_last,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 overflow,
  output logic [15:0]          drop_count
);
  localparam int WORD_W = 4 * DIN_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_LEN - 1);

  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

  logic [WORD_W-1:0] mem [2*VECTOR_LEN];

  logic [IDX_W-1:0]  wcnt_q;
  logic              wbank_q, rbank_q, drop_q;
  logic [1:0]        full_q, full_d;
  logic              overflow_q;
  logic [15:0]       drop_count_q;

  rd_state_t         state_q, state_d;
  logic [IDX_W:0]    raddr_q, raddr_d;
  logic              ram_vld_q, ram_vld_d;
  logic [IDX_W-1:0]  ram_idx_q, ram_idx_d;
  logic [WORD_W-1:0] ram_data_q;
  logic              rd_en;

  logic [WORD_W-1:0] out_data_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic              out_last_q, out_valid_q;

  logic beat0, frame_drop, wr_en, wr_done, drop_now, out_adv, rd_done;

  // The drop decision is taken at beat 0 and remembered for the rest of the frame.
  assign beat0      = (wcnt_q == '0);
  assign frame_drop = beat0 ? full_q[wbank_q] : drop_q;
  assign wr_en      = din_valid && !frame_drop;
  assign wr_done    = wr_en && (wcnt_q == LAST_IDX);
  assign drop_now   = din_valid && beat0 && full_q[wbank_q];
  assign out_adv    = !out_valid_q || dout_ready;
  assign rd_done    = out_valid_q && dout_ready && out_last_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wbank_q, wcnt_q}] <= {r11, r22, r12_re, r12_im};
  end

  always_ff @(posedge clk) begin
    if (rd_en) ram_data_q <= mem[{rbank_q, raddr_q[IDX_W-1:0]}];
  end

  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wbank_q] = 1'b1;
    if (rd_done) full_d[rbank_q] = 1'b0;
  end

  // Two-stage read pipeline (RAM register, output register); each stage refills
  // whenever the stage downstream of it moves, so a held-high ready streams gap-free.
  always_comb begin
    state_d   = state_q;
    raddr_d   = raddr_q;
    ram_vld_d = ram_vld_q;
    ram_idx_d = ram_idx_q;
    rd_en     = 1'b0;
    if (out_adv && ram_vld_q) ram_vld_d = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rbank_q]) begin
          rd_en     = 1'b1;
          raddr_d   = (IDX_W+1)'(1);
          ram_vld_d = 1'b1;
          ram_idx_d = '0;
          state_d   = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (!raddr_q[IDX_W] && (!ram_vld_q || out_adv)) begin
          rd_en     = 1'b1;
          raddr_d   = raddr_q + (IDX_W+1)'(1);
          ram_vld_d = 1'b1;
          ram_idx_d = raddr_q[IDX_W-1:0];
        end
        if (rd_done) begin
          state_d = RD_IDLE;
          raddr_d = '0;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q       <= '0;
      wbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
      drop_q       <= 1'b0;
      full_q       <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      state_q      <= RD_IDLE;
      raddr_q      <= '0;
      ram_vld_q    <= 1'b0;
      ram_idx_q    <= '0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      if (din_valid) begin
        wcnt_q <= wcnt_q + IDX_W'(1);
        if (beat0) drop_q <= full_q[wbank_q];
      end
      if (wr_done) wbank_q <= !wbank_q;
      if (rd_done) rbank_q <= !rbank_q;
      full_q     <= full_d;
      overflow_q <= drop_now;
      if (drop_now && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
      state_q   <= state_d;
      raddr_q   <= raddr_d;
      ram_vld_q <= ram_vld_d;
      ram_idx_q <= ram_idx_d;
      if (out_adv) begin
        out_valid_q <= ram_vld_q;
        if (ram_vld_q) begin
          out_data_q <= ram_data_q;
          out_idx_q  <= ram_idx_q;
          out_last_q <= (ram_idx_q == LAST_IDX);
        end
      end
    end
  end

  assign {dout_r11, dout_r22, dout_r12_re, dout_r12_im} = out_data_q;
  assign dout_index = out_idx_q;
  assign dout_last  = out_last_q;
  assign dout_valid = out_valid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_corr_frame_buffer.sv
// Testbench for corr_frame_buffer (VECTOR_LEN=8): directed frames plus a random
// stream checked every cycle against a frame-level bank/reader model.
module tb_corr_frame_buffer;
  localparam int W = 32;
  localparam int V = 8;

  logic clk = 1'b0;
  logic rst, din_valid, dout_ready;
  logic [4*W-1:0] cur_word;
  logic [W-1:0] dout_r11, dout_r22, dout_r12_re, dout_r12_im;
  logic [2:0]   dout_index;
  logic         dout_last, dout_valid, overflow;
  logic [15:0]  drop_count;
  logic [4*W-1:0] dout_word;

  assign dout_word = {dout_r11, dout_r22, dout_r12_re, dout_r12_im};

  corr_frame_buffer #(.DIN_WIDTH(W), .VECTOR_LEN(V)) dut (
    .clk(clk), .rst(rst),
    .r11(cur_word[127:96]), .r22(cur_word[95:64]),
    .r12_re(cur_word[63:32]), .r12_im(cur_word[31:0]),
    .din_valid(din_valid),
    .dout_r11(dout_r11), .dout_r22(dout_r22),
    .dout_r12_re(dout_r12_re), .dout_r12_im(dout_r12_im),
    .dout_index(dout_index), .dout_last(dout_last), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r11, r22, re, im;
    logic [2:0]   idx;
    logic         last;
  } vec_t;
  typedef struct {
    int           c;
    logic [2:0]   idx;
    logic         last;
    logic [127:0] data;
  } cap_t;

  vec_t   tbl [V];
  cap_t   cap [$];
  logic [127:0] frm [4][V];
  int errors = 0, checks = 0, cyc = 0, ovf_seen = 0;
  logic         hold_pend = 1'b0;
  logic [132:0] held;

  // Reference model: bank occupancy, write/read pointers, reader phase.
  logic [127:0] m_mem [2][V];
  bit m_full [2];
  int m_wbank, m_rbank, m_wcnt, m_rstate, m_ridx;
  bit m_dropping, m_ovf;
  int m_drops;

  function automatic logic [127:0] pack(vec_t t);
    return {t.r11, t.r22, t.re, t.im};
  endfunction

  function automatic logic [127:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_wbank = 0; m_rbank = 0; m_wcnt = 0; m_rstate = 0; m_ridx = 0;
    m_dropping = 0; m_ovf = 0; m_drops = 0;
  endtask

  // Applies one clock edge's worth of the buffering rules; bank state is sampled pre-edge.
  task automatic model_edge();
    bit f_old [2];
    int set_b, clr_b;
    if (rst) begin model_reset(); return; end
    f_old = m_full; set_b = -1; clr_b = -1; m_ovf = 0;
    if (din_valid) begin
      if (m_wcnt == 0) begin
        m_dropping = f_old[m_wbank];
        if (m_dropping) begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (!m_dropping) begin
        m_mem[m_wbank][m_wcnt] = cur_word;
        if (m_wcnt == V-1) begin set_b = m_wbank; m_wbank = 1 - m_wbank; end
      end
      m_wcnt = (m_wcnt + 1) % V;
    end
    // reader phases: 0 idle, 1 RAM read issued, 2 presenting word m_ridx
    if (m_rstate == 2) begin
      if (dout_ready) begin
        if (m_ridx == V-1) begin clr_b = m_rbank; m_rbank = 1 - m_rbank; m_rstate = 0; end
        else m_ridx++;
      end
    end else if (m_rstate == 1) begin
      m_rstate = 2; m_ridx = 0;
    end else if (f_old[m_rbank]) begin
      m_rstate = 1;
    end
    if (set_b >= 0) m_full[set_b] = 1;
    if (clr_b >= 0) m_full[clr_b] = 0;
  endtask

  task automatic check_model();
    chk("valid", 160'(dout_valid), 160'(m_rstate == 2));
    if (m_rstate == 2) begin
      chk("index", 160'(dout_index), 160'(m_ridx));
      chk("last", 160'(dout_last), 160'(m_ridx == V-1));
      chk("data", 160'(dout_word), 160'(m_mem[m_rbank][m_ridx]));
    end
    chk("overflow", 160'(overflow), 160'(m_ovf));
    chk("drop_count", 160'(drop_count), 160'(m_drops));
  endtask

  task automatic step(input logic v, input logic [127:0] w, input logic rdy, input logic r);
    din_valid = v; cur_word = w; dout_ready = rdy; rst = r;
    @(negedge clk);
    check_model();
    if (hold_pend) chk("hold", 160'({dout_valid, dout_index, dout_last, dout_word}), 160'(held));
    hold_pend = dout_valid && !dout_ready && !r;
    held = {dout_valid, dout_index, dout_last, dout_word};
    if (dout_valid && dout_ready && !r) cap.push_back('{cyc, dout_index, dout_last, dout_word});
    if (overflow) ovf_seen++;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  function automatic logic rp();
    return (cyc % 4 == 0) || (cyc % 4 == 3);
  endfunction

  task automatic check_tbl(string name);
    chk({name, "_count"}, 160'(cap.size()), 160'(V));
    for (int i = 0; i < V && i < cap.size(); i++) begin
      chk({name, "_idx"}, 160'(cap[i].idx), 160'(tbl[i].idx));
      chk({name, "_last"}, 160'(cap[i].last), 160'(tbl[i].last));
      chk({name, "_data"}, 160'(cap[i].data), 160'(pack(tbl[i])));
    end
  endtask

  task automatic check_cap(string name, int base, int f);
    for (int i = 0; i < V; i++) begin
      if (base + i < cap.size()) begin
        chk({name, "_idx"}, 160'(cap[base+i].idx), 160'(i));
        chk({name, "_data"}, 160'(cap[base+i].data), 160'(frm[f][i]));
      end else begin
        chk({name, "_missing"}, 160'(cap.size()), 160'(base + i + 1));
      end
    end
  endtask

  initial begin
    int last_beat, k, d0;
    for (int i = 0; i < V; i++) begin
      tbl[i].r11 = W'(i); tbl[i].r22 = W'(100 + i);
      tbl[i].re = W'(-i); tbl[i].im = W'(i << 4);
      tbl[i].idx = 3'(i); tbl[i].last = (i == V-1);
    end
    din_valid = 0; cur_word = '0; dout_ready = 0; rst = 1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    // reset state
    chk("rst_valid", 160'(dout_valid), 160'(0));
    chk("rst_data", 160'(dout_word), 160'(0));
    chk("rst_index", 160'(dout_index), 160'(0));
    chk("rst_last", 160'(dout_last), 160'(0));
    chk("rst_overflow", 160'(overflow), 160'(0));
    chk("rst_drops", 160'(drop_count), 160'(0));

    // single table frame, ready held high
    cap.delete();
    for (int i = 0; i < V; i++) step(1, pack(tbl[i]), 1, 0);
    last_beat = cyc - 1;
    repeat (16) step(0, '0, 1, 0);
    check_tbl("single");
    if (cap.size() == V) begin
      // word 0 is visible after the second edge following the last-beat edge
      chk("single_latency", 160'(cap[0].c - last_beat), 160'(3));
      chk("single_consecutive", 160'(cap[V-1].c - cap[0].c), 160'(V-1));
    end

    // backpressure with ready pattern 1,0,0,1
    cap.delete();
    for (int i = 0; i < V; i++) step(1, pack(tbl[i]), rp(), 0);
    repeat (40) step(0, '0, rp(), 0);
    check_tbl("bp");

    // overflow: three frames while stalled
    cap.delete(); ovf_seen = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < V; i++) begin
        frm[f][i] = rnd_word();
        step(1, frm[f][i], 0, 0);
      end
    repeat (4) step(0, '0, 0, 0);
    chk("ovf_pulses", 160'(ovf_seen), 160'(1));
    chk("ovf_drop_count", 160'(drop_count), 160'(1));
    repeat (40) step(0, '0, 1, 0);
    chk("ovf_words", 160'(cap.size()), 160'(2*V));
    check_cap("ovf_f1", 0, 0);
    check_cap("ovf_f2", V, 1);

    // gapped input, one beat every third cycle
    cap.delete(); k = 0; last_beat = 0;
    for (int i = 0; i < 3*V; i++) begin
      if (i % 3 == 0) begin
        frm[3][k] = rnd_word();
        step(1, frm[3][k], 1, 0);
        k++; last_beat = cyc - 1;
      end else step(0, '0, 1, 0);
    end
    repeat (20) step(0, '0, 1, 0);
    chk("gap_words", 160'(cap.size()), 160'(V));
    check_cap("gap", 0, 3);
    if (cap.size() > 0) chk("gap_latency", 160'(cap[0].c - last_beat), 160'(3));

    // reset at input beat 5, then a fresh frame
    for (int i = 0; i < 5; i++) step(1, rnd_word(), 1, 0);
    step(1, rnd_word(), 1, 1);
    chk("rst_mid_in_valid", 160'(dout_valid), 160'(0));
    cap.delete();
    for (int i = 0; i < V; i++) begin frm[1][i] = rnd_word(); step(1, frm[1][i], 1, 0); end
    repeat (16) step(0, '0, 1, 0);
    chk("rst_fresh_words", 160'(cap.size()), 160'(V));
    check_cap("rst_fresh", 0, 1);

    // reset while an output frame is stalled
    for (int i = 0; i < V; i++) begin frm[2][i] = rnd_word(); step(1, frm[2][i], 0, 0); end
    repeat (4) step(0, '0, 0, 0);
    chk("rst_mid_out_before", 160'(dout_valid), 160'(1));
    step(0, '0, 0, 1);
    chk("rst_mid_out_valid", 160'(dout_valid), 160'(0));
    cap.delete();
    for (int i = 0; i < V; i++) begin frm[2][i] = rnd_word(); step(1, frm[2][i], 1, 0); end
    repeat (16) step(0, '0, 1, 0);
    chk("rst_out_fresh_words", 160'(cap.size()), 160'(V));
    check_cap("rst_out_fresh", 0, 2);

    // ten back-to-back frames, ready high; words out must account for every undropped frame
    cap.delete(); d0 = m_drops;
    for (int i = 0; i < 10*V; i++) step(1, rnd_word(), 1, 0);
    repeat (40) step(0, '0, 1, 0);
    chk("cont_words", 160'(cap.size()), 160'(V * (10 - (m_drops - d0))));

    // random stream with random backpressure and rare resets
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, rnd_word(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 499) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
